// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_kbd_rx
//  Purpose  : PS/2 keyboard receiver. Synchronises ps2_clk/ps2_data into
//             clk_sys, deframes 11-bit frames (start, 8 data LSB first, odd
//             parity, stop), folds E0/F0 prefixes into extended/released and
//             pulses key_strobe per scan code. Stalled frames are aborted
//             after TIMEOUT clk_sys cycles without a ps2_clk fall.
//  Macro    : PS2_PARITY_CHECK_EN - when defined, a parity mismatch is a
//             frame error; otherwise the parity bit is consumed and ignored.
//  Ports    : clk_sys    - system clock, rising edge
//             reset_n    - asynchronous active-low reset
//             ps2_clk    - PS/2 clock (idles high)
//             ps2_data   - PS/2 data, sampled on ps2_clk falls
//             scan_code  - last non-prefix byte received
//             extended   - E0 prefix preceded scan_code
//             released   - F0 prefix preceded scan_code
//             key_strobe - one-cycle pulse when the three above update
//             frame_err  - one-cycle pulse on start/parity/stop/timeout error
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
  parameter int TIMEOUT = 20000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       released,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t      state_q;
  logic        clk_meta_q, clk_sync_q, clk_prev_q;
  logic        dat_meta_q, dat_sync_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [15:0] cnt_q;
  logic        ext_q, rel_q;
`ifdef PS2_PARITY_CHECK_EN
  logic        parity_q;
`endif

  logic ps2_fall;
  logic timeout_hit;
  logic frame_ok;

  assign ps2_fall    = clk_prev_q & ~clk_sync_q;
  // A fall in the same cycle wins: the line is alive, so no timeout.
  assign timeout_hit = (state_q != IDLE) && (cnt_q == C_TIMEOUT) && !ps2_fall;

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity: the XOR of all data bits and the parity bit must be 1.
  assign frame_ok = dat_sync_q & ((^shift_q) ^ parity_q);
`else
  assign frame_ok = dat_sync_q;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      cnt_q      <= 16'd0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q   <= 1'b0;
`endif
      scan_code  <= 8'h00;
      extended   <= 1'b0;
      released   <= 1'b0;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;

      // Inactivity counter: cleared on every fall, frozen in IDLE, saturating.
      if (ps2_fall) begin
        cnt_q <= 16'd0;
      end else if ((state_q != IDLE) && (cnt_q != C_TIMEOUT)) begin
        cnt_q <= cnt_q + 16'd1;
      end

      if (timeout_hit) begin
        state_q   <= IDLE;
        frame_err <= 1'b1;
        ext_q     <= 1'b0;
        rel_q     <= 1'b0;
        cnt_q     <= 16'd0;
      end else if (ps2_fall) begin
        case (state_q)
          IDLE: begin
            if (!dat_sync_q) begin
              state_q   <= DATA;
              bit_cnt_q <= 3'd0;
            end else begin
              frame_err <= 1'b1;
              ext_q     <= 1'b0;
              rel_q     <= 1'b0;
            end
          end
          DATA: begin
            shift_q   <= {dat_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= dat_sync_q;
`endif
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (frame_ok) begin
              if (shift_q == 8'hE0) begin
                ext_q <= 1'b1;
              end else if (shift_q == 8'hF0) begin
                rel_q <= 1'b1;
              end else begin
                scan_code  <= shift_q;
                extended   <= ext_q;
                released   <= rel_q;
                key_strobe <= 1'b1;
                ext_q      <= 1'b0;
                rel_q      <= 1'b0;
              end
            end else begin
              // Drop pending prefixes so they never attach across a bad frame.
              frame_err <= 1'b1;
              ext_q     <= 1'b0;
              rel_q     <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_kbd_rx
//  Purpose  : Directed self-checking bench for ps2_kbd_rx. Builds PS/2 frames
//             bit by bit, tracks key_strobe/frame_err pulses and compares
//             against hand-derived expectations. Follows PS2_PARITY_CHECK_EN
//             for the bad-parity case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

  localparam int C_TIMEOUT = 200;

  logic       clk_sys;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       extended;
  logic       released;
  logic       key_strobe;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_strobe = 0;
  int n_ferr   = 0;
  int n_both   = 0;
  int s0, e0;

  ps2_kbd_rx #(.TIMEOUT(C_TIMEOUT)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .extended  (extended),
    .released  (released),
    .key_strobe(key_strobe),
    .frame_err (frame_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk_sys) begin
    if (key_strobe) n_strobe++;
    if (frame_err)  n_ferr++;
    if (key_strobe && frame_err) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic pflip, input logic stop);
    return {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction

  task automatic bit_out(input logic b);
    @(negedge clk_sys) ps2_data = b;
    repeat (10) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk_sys);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) bit_out(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] d);
    send_bits(mk(d, 1'b0, 1'b1), 11);
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk_sys);
    chk("rst_scan", {24'd0, scan_code}, 32'h00);
    chk("rst_ext", {31'd0, extended}, 32'd0);
    chk("rst_rel", {31'd0, released}, 32'd0);
    chk("rst_strobe", {31'd0, key_strobe}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    // 0x1C with latency check on the stop bit.
    s0 = n_strobe;
    send_bits(mk(8'h1C, 1'b0, 1'b1), 10);
    @(negedge clk_sys) ps2_data = 1'b1;
    repeat (10) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("lat_2cyc", {31'd0, key_strobe}, 32'd0);
    @(negedge clk_sys);
    chk("lat_3cyc", {31'd0, key_strobe}, 32'd1);
    @(negedge clk_sys);
    chk("strobe_width", {31'd0, key_strobe}, 32'd0);
    repeat (16) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("a_cnt", n_strobe - s0, 1);
    chk("a_scan", {24'd0, scan_code}, 32'h1C);
    chk("a_ext", {31'd0, extended}, 32'd0);
    chk("a_rel", {31'd0, released}, 32'd0);

    // Break code F0 1C, then make 1C.
    s0 = n_strobe;
    send(8'hF0);
    send(8'h1C);
    chk("brk_cnt", n_strobe - s0, 1);
    chk("brk_scan", {24'd0, scan_code}, 32'h1C);
    chk("brk_rel", {31'd0, released}, 32'd1);
    chk("brk_ext", {31'd0, extended}, 32'd0);
    send(8'h1C);
    chk("mk_rel", {31'd0, released}, 32'd0);

    // Extended break E0 F0 75.
    s0 = n_strobe;
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("ebrk_cnt", n_strobe - s0, 1);
    chk("ebrk_scan", {24'd0, scan_code}, 32'h75);
    chk("ebrk_ext", {31'd0, extended}, 32'd1);
    chk("ebrk_rel", {31'd0, released}, 32'd1);
    chk("no_err_yet", n_ferr, 0);

    // Bad parity on 0x1C.
    s0 = n_strobe; e0 = n_ferr;
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_err", n_ferr - e0, 1);
    chk("par_strobe", n_strobe - s0, 0);
    chk("par_scan", {24'd0, scan_code}, 32'h75);
`else
    chk("par_err", n_ferr - e0, 0);
    chk("par_strobe", n_strobe - s0, 1);
    chk("par_scan", {24'd0, scan_code}, 32'h1C);
`endif

    // Bad start bit in IDLE.
    e0 = n_ferr;
    bit_out(1'b1);
    chk("start_err", n_ferr - e0, 1);

    // F0, then a frame with stop=0, then 1C: prefix must be dropped.
    s0 = n_strobe; e0 = n_ferr;
    send(8'hF0);
    send_bits(mk(8'h33, 1'b0, 1'b0), 11);
    send(8'h1C);
    chk("stop_err", n_ferr - e0, 1);
    chk("stop_strobe", n_strobe - s0, 1);
    chk("stop_rel", {31'd0, released}, 32'd0);

    // E0, then start + 4 bits and a stall beyond TIMEOUT, then 0x29.
    s0 = n_strobe; e0 = n_ferr;
    send(8'hE0);
    send_bits(mk(8'h29, 1'b0, 1'b1), 5);
    repeat (C_TIMEOUT + 5) @(negedge clk_sys);
    chk("to_err", n_ferr - e0, 1);
    chk("to_strobe", n_strobe - s0, 0);
    send(8'h29);
    chk("to_next_cnt", n_strobe - s0, 1);
    chk("to_next_scan", {24'd0, scan_code}, 32'h29);
    chk("to_next_ext", {31'd0, extended}, 32'd0);
    chk("to_err_once", n_ferr - e0, 1);

    // Reset between data bit 3 and bit 4.
    s0 = n_strobe; e0 = n_ferr;
    send_bits(mk(8'h29, 1'b0, 1'b1), 5);
    @(negedge clk_sys) reset_n = 1'b0;
    #1;
    chk("mrst_scan", {24'd0, scan_code}, 32'h00);
    chk("mrst_flags", {29'd0, extended, released, key_strobe}, 32'd0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    send(8'h5A);
    chk("mrst_cnt", n_strobe - s0, 1);
    chk("mrst_scan2", {24'd0, scan_code}, 32'h5A);
    chk("mrst_noerr", n_ferr - e0, 0);

    chk("excl", n_both, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 20000, meaning the number of clk_sys cycles without a ps2_clk falling edge that aborts a frame in progress (valid range 16..65535).
REQ-002 SHALL have port clk_sys, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port ps2_clk, input, 1 bit: PS/2 clock from the mist_io keyboard emulator; idles high.
REQ-005 SHALL have port ps2_data, input, 1 bit: PS/2 data; sampled on ps2_clk falling edges.
REQ-006 SHALL have port scan_code, output, 8 bits: the last non-prefix byte received.
REQ-007 SHALL have port extended, output, 1 bit: E0 prefix preceded scan_code.
REQ-008 SHALL have port released, output, 1 bit: F0 prefix preceded scan_code.
REQ-009 SHALL have port key_strobe, output, 1 bit: one-cycle pulse when scan_code, extended and released update.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad start bit, parity error, stop error or timeout.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-FF synchronisers and detect a falling edge as prev=1, cur=0 on synchronised ps2_clk.
REQ-012 SHALL run states IDLE, DATA, PARITY, STOP, and advance only on a detected falling edge, except for timeout.
REQ-013 IDLE: on an edge, sampled data 0 goes to DATA with bit count 0; sampled data 1 pulses frame_err and stays in IDLE.
REQ-014 DATA: SHALL shift bits in LSB first, and go to PARITY after the 8th bit (bit count wraps 7 to 0).
REQ-015 PARITY: SHALL capture the parity bit; odd parity means data XOR parity = 1.
REQ-016 STOP: sampled 1 with parity OK completes the frame; any other case pulses frame_err and discards the byte; both cases return to IDLE.
REQ-017 On a completed byte 0xE0, SHALL set the internal ext flag and produce no strobe.
REQ-018 On a completed byte 0xF0, SHALL set the internal rel flag and produce no strobe.
REQ-019 On any other completed byte, SHALL latch scan_code, copy ext and rel to extended and released, pulse key_strobe, and clear both flags.
REQ-020 key_strobe SHALL assert on the cycle after the stop-bit edge is detected: a latency of 3 clk_sys cycles from the raw ps2_clk fall.
REQ-021 Timeout: the cycle counter SHALL reset on every falling edge and increment while the state is not IDLE.
REQ-022 When the counter reaches TIMEOUT, SHALL go to IDLE, pulse frame_err, and clear ext and rel.
REQ-023 The timeout counter SHALL saturate and not run while in IDLE.
REQ-024 Frame errors SHALL clear ext and rel, so that a prefix is never applied across a corrupted frame.
REQ-025 frame_err and key_strobe SHALL never assert in the same cycle.
REQ-026 scan_code, extended and released SHALL hold their values between strobes.

Reset
REQ-027 reset_n low SHALL, asynchronously:
  - force state to IDLE and the bit count, shift register and counter to 0;
  - clear ext and rel;
  - set scan_code=0x00, extended=0, released=0, key_strobe=0, frame_err=0;
  - preset the synchroniser flops to 1.
REQ-028 Reset deasserted mid-frame SHALL start cleanly from IDLE; the partial frame is lost and no error pulse is produced.

Configuration
REQ-029 Macro PS2_PARITY_CHECK_EN defined: the parity mismatch of REQ-016 SHALL cause frame_err and discard the byte.
REQ-030 Macro PS2_PARITY_CHECK_EN undefined: the parity bit SHALL be clocked and ignored, and only start, stop and timeout errors flag frame_err.

Verification
REQ-031 Frame 0x1C (A key) with parity 0 and stop 1 -> key_strobe once, scan_code=0x1C, extended=0, released=0.
REQ-032 Frames F0, 1C -> one strobe only, scan_code=0x1C, released=1, extended=0; the next frame 0x1C gives released=0.
REQ-033 Frames E0, F0, 75 -> one strobe, scan_code=0x75, extended=1, released=1.
REQ-034 Frame 0x1C with parity 1 -> with the macro: frame_err pulse, no strobe, scan_code unchanged; without the macro: strobe with 0x1C.
REQ-035 Start bit and 4 data bits then ps2_clk held high for TIMEOUT+5 cycles -> exactly one frame_err and state IDLE; a following valid 0x29 strobes correctly.
REQ-036 reset_n pulsed low between bit 3 and bit 4 of a frame -> all outputs 0 immediately; the next full frame 0x5A strobes scan_code=0x5A.
